// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit bus master.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAwW,
    StB,
    StResp
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store data/strobe shifting, load extract/extend,
// and the alignment check.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = 8
) (
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic [DATA_W-1:0] wdata_aligned,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [4:0]        shamt;
  logic [3:0]        strb_base;
  logic [3:0]        strb_sh;
  logic [DATA_W-1:0] rdata_sh;

  assign shamt         = {off, 3'b000};
  assign wdata_aligned = wdata << shamt;
  assign rdata_sh      = rdata >> shamt;

  assign misaligned = (size == SZ_H && off[0]) ||
                      (size == SZ_W && off != 2'd0) ||
                      (size == 2'd3);

  always_comb begin
    strb_base = 4'b1111;
    case (size)
      SZ_B:    strb_base = 4'b0001;
      SZ_H:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  assign strb_sh = strb_base << off;
  assign wstrb   = {{(STRB_W-4){1'b0}}, strb_sh};

  always_comb begin
    rdata_ext = rdata_sh;
    case (size)
      SZ_B:    rdata_ext = {{(DATA_W-8){~is_unsigned & rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_H:    rdata_ext = {{(DATA_W-16){~is_unsigned & rdata_sh[15]}}, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU bus master: one load or store at a time onto an AXI-lite data memory port,
// with result handed to write-back over a valid/ready handshake.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [ADDR_W-1:0] mem_awaddr,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic [1:0]        mem_bresp,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [1:0]        mem_rresp,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic              uns_q, uns_d;
  logic              arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic              out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [DATA_W-1:0] out_rdata_q, out_rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic [1:0]        size_sel, off_sel;
  logic              misaligned;
  logic [DATA_W-1:0] wdata_al, rdata_ext;
  logic [STRB_W-1:0] wstrb_al;
  logic [ADDR_W-1:0] addr_word;
  logic              aw_hs, w_hs;

  // Idle decodes the incoming request; afterwards the latched size/offset drive extraction.
  assign size_sel  = (state_q == StIdle) ? in_size : size_q;
  assign off_sel   = (state_q == StIdle) ? in_addr[1:0] : off_q;
  assign addr_word = {in_addr[ADDR_W-1:2], 2'b00};

  lsu_align #(
    .DATA_W(DATA_W),
    .STRB_W(STRB_W)
  ) u_align (
    .size         (size_sel),
    .off          (off_sel),
    .is_unsigned  (uns_q),
    .wdata        (in_wdata),
    .rdata        (mem_rdata),
    .misaligned   (misaligned),
    .wdata_aligned(wdata_al),
    .wstrb        (wstrb_al),
    .rdata_ext    (rdata_ext)
  );

  assign aw_hs = awvalid_q & mem_awready;
  assign w_hs  = wvalid_q & mem_wready;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    arvalid_d   = arvalid_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_rdata_d = out_rdata_q;
    wdata_d     = wdata_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wstrb_d     = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          size_d = in_size;
          off_d  = in_addr[1:0];
          uns_d  = in_unsigned;
          if (misaligned) begin
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = '0;
            state_d     = StResp;
          end else if (in_is_store) begin
            awaddr_d  = addr_word;
            wdata_d   = wdata_al;
            wstrb_d   = wstrb_al;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StAwW;
          end else begin
            araddr_d  = addr_word;
            arvalid_d = 1'b1;
            state_d   = StAr;
          end
        end
      end
      StAr: begin
        if (mem_arready) begin
          arvalid_d = 1'b0;
          state_d   = StR;
        end
      end
      StR: begin
        if (mem_rvalid) begin
          out_valid_d = 1'b1;
          out_err_d   = (mem_rresp != RESP_OKAY);
          out_rdata_d = (mem_rresp != RESP_OKAY) ? '0 : rdata_ext;
          state_d     = StResp;
        end
      end
      StAwW: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // Either channel may have completed in an earlier cycle.
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) state_d = StB;
      end
      StB: begin
        if (mem_bvalid) begin
          out_valid_d = 1'b1;
          out_err_d   = (mem_bresp != RESP_OKAY);
          out_rdata_d = '0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      size_q      <= SZ_B;
      off_q       <= 2'd0;
      uns_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= '0;
      wdata_q     <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_rdata_q <= out_rdata_d;
      wdata_q     <= wdata_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = out_valid_q;
  assign out_err     = out_err_q;
  assign out_rdata   = out_rdata_q;
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_rready  = (state_q == StAr) || (state_q == StR);
  assign mem_awvalid = awvalid_q;
  assign mem_awaddr  = awaddr_q;
  assign mem_wvalid  = wvalid_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign mem_bready  = (state_q == StAwW) || (state_q == StB);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: registered AXI-lite memory model plus a
// result scoreboard.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_store, in_unsigned;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
  logic [31:0] mem_awaddr, mem_wdata, mem_araddr, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic [1:0]  mem_bresp, mem_rresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_store(in_is_store),
    .in_size    (in_size),
    .in_unsigned(in_unsigned),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdata  (out_rdata),
    .out_err    (out_err),
    .mem_awvalid(mem_awvalid),
    .mem_awready(mem_awready),
    .mem_awaddr (mem_awaddr),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_bvalid (mem_bvalid),
    .mem_bready (mem_bready),
    .mem_bresp  (mem_bresp),
    .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready),
    .mem_araddr (mem_araddr),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rresp  (mem_rresp),
    .mem_rdata  (mem_rdata)
  );

  // Slave controls, written only by the main process.
  bit r_hold = 1'b0, w_always = 1'b0, resp_err = 1'b0;
  int aw_stall = 0;

  // Slave model: readies pulse one cycle after valid is seen.
  logic [31:0] mem [16];
  logic        arready_q, awready_q, wready_q, rvalid_q, bvalid_q, r_pend, aw_done, w_done;
  logic [31:0] rdata_q, aw_addr_l, w_data_l, addr_v, data_v;
  logic [7:0]  w_strb_l, strb_v;
  int          aw_wait;
  logic        aw_hs, w_hs, aw_ok, w_ok;

  assign mem_arready = arready_q;
  assign mem_awready = awready_q;
  assign mem_wready  = w_always | wready_q;
  assign mem_rvalid  = rvalid_q;
  assign mem_bvalid  = bvalid_q;
  assign mem_rdata   = rdata_q;
  assign mem_rresp   = resp_err ? 2'b10 : 2'b00;
  assign mem_bresp   = resp_err ? 2'b10 : 2'b00;
  assign aw_hs  = mem_awvalid & mem_awready;
  assign w_hs   = mem_wvalid & mem_wready;
  assign aw_ok  = aw_done | aw_hs;
  assign w_ok   = w_done | w_hs;
  assign addr_v = aw_hs ? mem_awaddr : aw_addr_l;
  assign data_v = w_hs ? mem_wdata : w_data_l;
  assign strb_v = w_hs ? mem_wstrb : w_strb_l;

  always @(posedge clk) begin
    if (rst) begin
      arready_q <= 1'b0; awready_q <= 1'b0; wready_q <= 1'b0;
      rvalid_q  <= 1'b0; bvalid_q  <= 1'b0; r_pend   <= 1'b0;
      aw_done   <= 1'b0; w_done    <= 1'b0; aw_wait  <= 0;
      rdata_q   <= '0;   aw_addr_l <= '0;   w_data_l <= '0; w_strb_l <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h80FF1234;
      mem[1] <= 32'h12345678;
    end else begin
      arready_q <= mem_arvalid && !arready_q;
      if (mem_arvalid && arready_q) begin
        rdata_q <= mem[mem_araddr[5:2]];
        if (r_hold) r_pend <= 1'b1;
        else        rvalid_q <= 1'b1;
      end else if (r_pend && !r_hold) begin
        rvalid_q <= 1'b1;
        r_pend   <= 1'b0;
      end else if (rvalid_q && mem_rready) begin
        rvalid_q <= 1'b0;
      end
      if (mem_awvalid && !awready_q) begin
        if (aw_wait >= aw_stall) awready_q <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end else begin
        awready_q <= 1'b0;
        if (!mem_awvalid) aw_wait <= 0;
      end
      wready_q <= mem_wvalid && !wready_q && !w_always;
      if (aw_hs) aw_addr_l <= mem_awaddr;
      if (w_hs) begin
        w_data_l <= mem_wdata;
        w_strb_l <= mem_wstrb;
      end
      if (aw_ok && w_ok && !bvalid_q) begin
        bvalid_q <= 1'b1;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        for (int i = 0; i < 4; i++)
          if (strb_v[i]) mem[addr_v[5:2]][8*i +: 8] <= data_v[8*i +: 8];
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (bvalid_q && mem_bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  int          ar_cyc = 0, ar_hs_cnt = 0, aw_cyc = 0, w_cyc = 0, b_hs_cnt = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [7:0]  cap_wstrb = '0;

  always @(negedge clk) begin
    if (mem_arvalid) ar_cyc <= ar_cyc + 1;
    if (mem_awvalid) aw_cyc <= aw_cyc + 1;
    if (mem_wvalid)  w_cyc  <= w_cyc + 1;
    if (mem_arvalid && mem_arready) begin
      ar_hs_cnt  <= ar_hs_cnt + 1;
      cap_araddr <= mem_araddr;
    end
    if (mem_awvalid && mem_awready) cap_awaddr <= mem_awaddr;
    if (mem_wvalid && mem_wready) begin
      cap_wdata <= mem_wdata;
      cap_wstrb <= mem_wstrb;
    end
    if (mem_bvalid && mem_bready) b_hs_cnt <= b_hs_cnt + 1;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                        input int hold);
    exp_t e;
    int   lat;
    bit   seen;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    check_val({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_is_store = st; in_size = sz; in_unsigned = uns;
    in_addr = addr; in_wdata = wd;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      step();
      lat++;
      in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    e = sb_q.pop_front();
    if (seen) begin
      check_val({tag, ".rdata"}, out_rdata, e.rdata);
      check_val({tag, ".err"}, 32'(out_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        step();
        check_val({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, ".hold_rdata"}, out_rdata, e.rdata);
        check_val({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_val({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
      check_val({tag, ".idle_err"}, 32'(out_err), 32'd0);
    end
  endtask

  initial begin
    int snap_ar, snap_aw, snap_w, snap_b, snap_arhs, n;
    rst = 1'b1; in_valid = 1'b0; in_is_store = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_val("rst.in_ready", 32'(in_ready), 32'd1);
    check_val("rst.out_valid", 32'(out_valid), 32'd0);
    check_val("rst.out_err", 32'(out_err), 32'd0);
    check_val("rst.out_rdata", out_rdata, 32'd0);
    check_val("rst.valids", {26'd0, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid,
                             mem_bready, out_valid}, 32'd0);
    check_val("rst.araddr", mem_araddr, 32'd0);
    check_val("rst.awaddr", mem_awaddr, 32'd0);
    check_val("rst.wdata", mem_wdata, 32'd0);
    check_val("rst.wstrb", 32'(mem_wstrb), 32'd0);

    do_req("lw4", 1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h12345678, 1'b0, 4, 0);
    check_val("lw4.araddr", cap_araddr, 32'h80000004);
    do_req("lb3", 1'b0, 2'd0, 1'b0, 32'h80000003, 32'h0, 32'hFFFFFF80, 1'b0, 4, 0);
    check_val("lb3.araddr", cap_araddr, 32'h80000000);
    do_req("lbu3", 1'b0, 2'd0, 1'b1, 32'h80000003, 32'h0, 32'h00000080, 1'b0, 4, 0);
    do_req("lh0", 1'b0, 2'd1, 1'b0, 32'h80000000, 32'h0, 32'h00001234, 1'b0, 4, 0);
    do_req("lh2", 1'b0, 2'd1, 1'b0, 32'h80000002, 32'h0, 32'hFFFF80FF, 1'b0, 4, 0);

    do_req("sh2", 1'b1, 2'd1, 1'b0, 32'h80000002, 32'h0000ABCD, 32'h0, 1'b0, 4, 0);
    check_val("sh2.awaddr", cap_awaddr, 32'h80000000);
    check_val("sh2.wdata", cap_wdata, 32'hABCD0000);
    check_val("sh2.wstrb", 32'(cap_wstrb), 32'h0C);
    do_req("lhu2", 1'b0, 2'd1, 1'b1, 32'h80000002, 32'h0, 32'h0000ABCD, 1'b0, 4, 0);
    do_req("lh2b", 1'b0, 2'd1, 1'b0, 32'h80000002, 32'h0, 32'hFFFFABCD, 1'b0, 4, 0);

    do_req("sb5", 1'b1, 2'd0, 1'b0, 32'h80000005, 32'h000000EE, 32'h0, 1'b0, 4, 0);
    check_val("sb5.wdata", cap_wdata, 32'h0000EE00);
    check_val("sb5.wstrb", 32'(cap_wstrb), 32'h02);
    do_req("lw4b", 1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h1234EE78, 1'b0, 4, 0);

    snap_ar = ar_cyc;
    snap_aw = aw_cyc;
    do_req("lw1", 1'b0, 2'd2, 1'b0, 32'h80000001, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("sw2", 1'b1, 2'd2, 1'b0, 32'h80000002, 32'h11223344, 32'h0, 1'b1, 1, 0);
    do_req("sz3", 1'b0, 2'd3, 1'b0, 32'h80000000, 32'h0, 32'h0, 1'b1, 1, 0);
    check_val("misalign.no_ar", 32'(ar_cyc - snap_ar), 32'd0);
    check_val("misalign.no_aw", 32'(aw_cyc - snap_aw), 32'd0);

    aw_stall = 2;
    w_always = 1'b1;
    snap_aw = aw_cyc; snap_w = w_cyc; snap_b = b_hs_cnt;
    do_req("sw8stall", 1'b1, 2'd2, 1'b0, 32'h80000008, 32'hDEADBEEF, 32'h0, 1'b0, 6, 3);
    check_val("sw8stall.aw_cycles", 32'(aw_cyc - snap_aw), 32'd4);
    check_val("sw8stall.w_cycles", 32'(w_cyc - snap_w), 32'd1);
    check_val("sw8stall.b_count", 32'(b_hs_cnt - snap_b), 32'd1);
    aw_stall = 0;
    w_always = 1'b0;
    do_req("lw8", 1'b0, 2'd2, 1'b0, 32'h80000008, 32'h0, 32'hDEADBEEF, 1'b0, 4, 0);

    resp_err = 1'b1;
    do_req("lw_slverr", 1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h0, 1'b1, 4, 0);
    do_req("sw_slverr", 1'b1, 2'd2, 1'b0, 32'h8000000C, 32'h55AA55AA, 32'h0, 1'b1, 4, 0);
    resp_err = 1'b0;

    // Abandon a load while the read data is held off.
    r_hold = 1'b1;
    snap_arhs = ar_hs_cnt;
    in_valid = 1'b1; in_is_store = 1'b0; in_size = 2'd2; in_unsigned = 1'b0;
    in_addr = 32'h80000004;
    step();
    in_valid = 1'b0;
    n = 0;
    while (ar_hs_cnt == snap_arhs && n < 10) begin
      step();
      n++;
    end
    check_val("rstR.ar_handshake", 32'(ar_hs_cnt - snap_arhs), 32'd1);
    step();
    check_val("rstR.in_r_rready", 32'(mem_rready), 32'd1);
    check_val("rstR.in_r_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r_hold = 1'b0;
    check_val("rstR.in_ready", 32'(in_ready), 32'd1);
    check_val("rstR.valids", {26'd0, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid,
                              mem_bready, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rstR.no_resp", 32'(out_valid), 32'd0);
    end
    do_req("rstR.lw4", 1'b0, 2'd2, 1'b0, 32'h80000004, 32'h0, 32'h12345678, 1'b0, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
